// File: rtl/moving_average_master.sv
// moving_average_master
//   Streaming moving-average filter for 10-bit unsigned samples. Four running
//   averages (windows of 2, 4, 8 and 16 samples) are kept in parallel from a
//   shared 16-entry sample history. A 2-bit select chooses which average is
//   registered to the output one clock after each accepted sample.
//
//   Optional build macro: MOVING_AVERAGE_ROUND_EN
//     undefined : average = floor(sum / N)
//     defined   : average = floor((sum + N/2) / N)   (round half up)
//
// Ports (tiny-tapeout user-project pinout):
//   clk      in   system clock, rising-edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   design enable; samples accepted only when 1
//   ui_in    in   sample bits [7:0]
//   uio_in   in   [0] strobe_in, [3:2] sample bits [9:8], [7:6] filter select
//   uo_out   out  average bits [7:0]
//   uio_out  out  [1] strobe_out, [5:4] average bits [9:8], others 0
//   uio_oe   out  constant 8'b0011_0010
module moving_average_master #(
  parameter int DATA_W    = 10,
  parameter int MAX_LOG2N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DEPTH = 1 << MAX_LOG2N;
  localparam int SUM_W = DATA_W + MAX_LOG2N;

  logic [DATA_W-1:0] hist [DEPTH];
  logic [SUM_W-1:0]  sum  [MAX_LOG2N];
  logic [DATA_W-1:0] avg  [MAX_LOG2N];

  logic [DATA_W-1:0] sample;
  logic [1:0]        filter_select;
  logic              strobe_in;
  logic              accept;
  logic              accept_d;
  logic [DATA_W-1:0] data_out;
  logic              strobe_out;

  // Pins that carry no function; the name keeps lint quiet about them.
  logic unused_pins;
  assign unused_pins = &{1'b0, uio_in[1], uio_in[5:4]};

  assign sample        = {uio_in[3:2], ui_in};
  assign strobe_in     = uio_in[0];
  assign filter_select = uio_in[7:6];
  assign accept        = ena & strobe_in;

  // Shift history (newest at index 0) and update every running sum. Window
  // index i covers N = 2^(i+1) samples, so the sample falling out of that
  // window is the one currently sitting at hist[N-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) hist[j] <= '0;
      for (int i = 0; i < MAX_LOG2N; i++) sum[i] <= '0;
    end else if (accept) begin
      hist[0] <= sample;
      for (int j = 1; j < DEPTH; j++) hist[j] <= hist[j-1];
      for (int i = 0; i < MAX_LOG2N; i++)
        sum[i] <= sum[i] + SUM_W'(sample) - SUM_W'(hist[(2 << i) - 1]);
    end
  end

  // Divide each sum by its window size. The extra bit on the widened sum
  // leaves headroom for the rounding offset.
  always_comb begin
    for (int i = 0; i < MAX_LOG2N; i++) begin
      logic [SUM_W:0] widened;
      widened = {1'b0, sum[i]};
`ifdef MOVING_AVERAGE_ROUND_EN
      widened = widened + ((SUM_W + 1)'(1) << i);
`endif
      avg[i] = DATA_W'(widened >> (i + 1));
    end
  end

  // One clock after an accept, the chosen average is registered and the
  // output strobe pulses. The pending flag ignores ena so an accepted sample
  // always produces its output even if ena drops in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_d   <= 1'b0;
      strobe_out <= 1'b0;
      data_out   <= '0;
    end else begin
      accept_d   <= accept;
      strobe_out <= accept_d;
      if (accept_d) data_out <= avg[filter_select];
    end
  end

  assign uo_out  = data_out[7:0];
  assign uio_out = {2'b00, data_out[9:8], 2'b00, strobe_out, 1'b0};
  assign uio_oe  = 8'b0011_0010;

endmodule

// File: tb/tb_moving_average_master.sv
// Testbench for moving_average_master. Stimulus pushes the hand-derived
// expected average into a scoreboard queue at each accept edge; a monitor
// pops and compares whenever strobe_out is seen high.
module tb_moving_average_master;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [9:0] sample;
  logic [1:0] sel;
  logic       strobe;

  typedef struct {
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t       sb [$];
  int         total_cnt;
  int         pass_cnt;
  logic [9:0] last_exp;

  assign ui_in  = sample[7:0];
  assign uio_in = {sel, 2'b00, sample[9:8], 1'b0, strobe};

  moving_average_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [9:0] data_out   = {uio_out[5:4], uo_out};
  wire       strobe_out = uio_out[1];

  // Expected average of a window sum, in the same arithmetic as the spec.
  function automatic int exp_avg(input int s, input int lg);
`ifdef MOVING_AVERAGE_ROUND_EN
    return (s + (1 << (lg - 1))) >> lg;
`else
    return s >> lg;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic push_exp(input int v, input string name);
    exp_t e;
    e.val    = 10'(v);
    e.name   = name;
    last_exp = 10'(v);
    sb.push_back(e);
  endtask

  // Monitor: every strobe_out must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && strobe_out) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput(e.name, data_out, e.val);
      end
    end
  end

  task automatic doReset();
    strobe = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One accepted sample followed by idle_cycles clocks with strobe low.
  task automatic applyStimulus(input int v, input logic [1:0] s, input int expected,
                               input string name, input int idle_cycles);
    sample = 10'(v);
    sel    = s;
    strobe = 1'b1;
    @(posedge clk);
    push_exp(expected, name);
    #1;
    strobe = 1'b0;
    repeat (idle_cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int hsum;
    int lg;
    total_cnt = 0;
    pass_cnt  = 0;
    last_exp  = '0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    strobe    = 1'b0;
    sample    = '0;
    sel       = 2'b00;
    #1;
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_strobe", strobe_out, 0);
    checkOutput("uio_oe", uio_oe, 8'h32);
    checkOutput("uio_out_other_bits", uio_out & 8'hCD, 0);
    doReset();

    // Single sample: pulse timing and first-fill averages.
    sample = 10'd100;
    sel    = 2'b00;
    strobe = 1'b1;
    @(posedge clk);
    push_exp(50, "single_100");
    #1;
    strobe = 1'b0;
    checkOutput("pulse_before", strobe_out, 0);
    @(posedge clk);
    #1;
    checkOutput("pulse_high", strobe_out, 1);
    @(posedge clk);
    #1;
    checkOutput("pulse_after", strobe_out, 0);
    applyStimulus(300, 2'b00, 200, "single_300", 3);

    // Ramp 0..249, one strobe every two clocks, select stepping through windows.
    doReset();
    for (int k = 0; k < 250; k++) begin
      logic [1:0] s;
      s  = (k < 50) ? 2'b00 : (k < 100) ? 2'b01 : (k < 150) ? 2'b10 : 2'b11;
      lg = int'(s) + 1;
      hsum = 0;
      for (int j = 0; j < (1 << lg); j++) if (k - j >= 0) hsum += k - j;
      applyStimulus(k, s, exp_avg(hsum, lg), $sformatf("ramp_k%0d", k), 1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Full-scale constant back-to-back, then back to zero, 16-sample window.
    doReset();
    sel    = 2'b11;
    strobe = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      sample = 10'd1023;
      @(posedge clk);
      push_exp(exp_avg(1023 * k, 4), $sformatf("max_k%0d", k));
      #1;
    end
    for (int k = 1; k <= 16; k++) begin
      sample = 10'd0;
      @(posedge clk);
      push_exp(exp_avg(1023 * (16 - k), 4), $sformatf("zero_k%0d", k));
      #1;
    end
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Rounding distinction: 1 then 2 with N=2.
    doReset();
    applyStimulus(1, 2'b00, exp_avg(1, 1), "round_first", 2);
    applyStimulus(2, 2'b00, exp_avg(3, 1), "round_second", 2);

    // Reset between accept edge and output edge discards the pending update.
    sample = 10'd500;
    sel    = 2'b10;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data", data_out, 0);
    checkOutput("midreset_strobe", strobe_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_release_strobe", strobe_out, 0);
    applyStimulus(8, 2'b10, 1, "after_reset_8", 3);

    // ena=0 blocks accepts; outputs hold.
    ena    = 1'b0;
    sample = 10'd777;
    strobe = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("ena0_strobe_c%0d", c), strobe_out, 0);
      checkOutput($sformatf("ena0_data_c%0d", c), data_out, last_exp);
    end
    strobe = 1'b0;

    // Accept with ena=1, then drop ena: the pending output still appears.
    ena    = 1'b1;
    sample = 10'd16;
    strobe = 1'b1;
    @(posedge clk);
    push_exp(exp_avg(24, 3), "pending_with_ena0");
    #1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    strobe = 1'b0;
    ena    = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/moving_average_master.md
Name: moving_average_master

Overview:
- Streaming moving-average filter for 10-bit unsigned samples.
- Four averagers (window N = 2, 4, 8, 16) run in parallel on every accepted sample; a 2-bit select picks which result is driven out.
- Wrapped in the standard tiny-tapeout user-project pinout: low 8 data bits on dedicated pins, upper bits, strobes and select on the bidirectional bank.

Parameters:
- DATA_W, 10, sample and result width (fixed by pin map; not to be overridden).
- MAX_LOG2N, 4, log2 of the largest window (16).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; when 0 no samples are accepted.
- ui_in  input  8  sample bits [7:0].
- uio_in  input  8  bit0 strobe_in; bit1 unused; bits[3:2] sample bits [9:8]; bits[5:4] unused; bits[7:6] filter_select.
- uo_out  output  8  average bits [7:0].
- uio_out  output  8  bit1 strobe_out; bits[5:4] average bits [9:8]; all other bits driven 0.
- uio_oe  output  8  constant 8'b0011_0010 (bits 1, 4, 5 are outputs).

Behaviour:
- Sample accept: on each rising clk edge with ena=1 and strobe_in=1, sample x = {uio_in[3:2], ui_in}.
  - Level-sensitive: every high cycle is a separate sample.
  - Back-to-back strobes are legal at one sample per clock.
- History: one 16-entry shift register of 10-bit samples, newest at index 0; all four windows draw from it.
- Running sums: per window N, 14-bit unsigned; on accept, sum_N <= sum_N + x - hist[N-1] (the sample leaving window N). No overflow possible.
- Average: avg_N = sum_N >> log2(N), truncating (floor), 10-bit result.
- filter_select mapping: 00 gives N=2, 01 gives N=4, 10 gives N=8, 11 gives N=16.
- Select changes take effect on the next output update. History and sums are never cleared by a select change, so switching windows is seamless.
- Output timing:
  - At edge E the sample is accepted and history/sums update.
  - At edge E+1, data_out is registered from the selected avg and strobe_out is registered to 1.
  - strobe_out is a one-cycle pulse per accepted sample, asserted continuously during a run of consecutive accepts.
  - data_out holds its value between updates.
- Window fill: before N samples have arrived, the missing history entries read as 0. The output ramps up, e.g. first sample 100 with N=2 gives 50.
- Reset (rst_n=0, any time, asynchronous): history, all sums, data_out and strobe_out go to 0. A pending output update is discarded. The first accept after release starts from empty history.
- ena=0: no accepts; the pending strobe_out still completes; outputs hold.

Optional Feature:
- Macro MOVING_AVERAGE_ROUND_EN.
- Defined: avg_N = (sum_N + N/2) >> log2(N), i.e. round half up. The result cannot exceed 1023, so no saturation is needed.
- Undefined: truncating average as specified above.
- Nothing else changes (timing, ports, reset).

Test Plan:
- Reset then single strobe with sample 100, select 00 -> strobe_out high exactly one cycle, starting one cycle after the accept edge; data_out = 50. Then sample 300 -> 200.
- Ramp 0..249, one strobe every 2 clocks, select 00 -> after sample k≥1, data_out = k-1.
- Same ramp, select 01 (after ≥4 samples) -> k-2; select 10 (≥8 samples) -> k-4; select 11 (≥16 samples) -> k-8.
- Constant 1023 for 16 strobes, select 11 -> data_out = 1023 (checks 14-bit sum, no overflow). Then 16 strobes of 0 -> 0.
- Reset asserted mid-run, between accept edge and output edge -> data_out = 0 and strobe_out = 0 immediately. No strobe_out pulse follows release. Next sample 8 with select 10 -> 1.
- With MOVING_AVERAGE_ROUND_EN, select 00, samples 1 then 2 -> data_out = 2 (truncating build gives 1). Also: ena=0 with strobe_in=1 -> no strobe_out and data_out unchanged.
